alu_system_ctrl: RTL and testbench
==================================

Name: alu_system_ctrl

Overview:
- Hardwired control sequencer that sits directly upstream of ALUSystem and drives every one of its select, enable and function inputs.
- Runs a fixed fetch/decode/execute loop:
  - fetches a 16-bit instruction as two bytes from memory into IR, addressed by PC;
  - decodes IROut;
  - issues one or two execute micro-steps.
- Latches ALU flags for conditional branches.

Parameters:
- HALT_EN, 1, 1 = opcode 0xF halts the sequencer; 0 = opcode 0xF is a NOP.

Ports:
- Clock  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- IROut  in  16  instruction register contents from ALUSystem
- ALUOutFlag  in  4  live ALU flags: [3]=Z, [2]=C, [1]=N, [0]=O
- ARF_OutASel, ARF_OutBSel  out  2 each  ARF read selects: 00=AR, 01=SP, 10=PCpast, 11=PC
- ARF_FunSel, RF_FunSel, IR_Funsel  out  2 each  00=clear, 01=load, 10=dec, 11=inc
- ARF_RSel  out  4  ARF enables: [3]=AR, [2]=SP, [1]=PCpast, [0]=PC
- RF_RSel  out  4  RF enables: [3]=R1 .. [0]=R4
- RF_TSel  out  4  temp-register enables: [3]=T1 .. [0]=T4
- RF_OutASel, RF_OutBSel  out  3 each  RF read selects: 100=R1, 101=R2, 110=R3, 111=R4
- ALU_FunSel  out  4  ALU operation code
- Mem_WR  out  1  1 = write
- Mem_CS  out  1  0 = memory selected
- IR_Enable, IR_LH  out  1 each  IR load enable; 0 = low byte, 1 = high byte
- MuxASel, MuxBSel  out  2 each  00=ALUOut, 01=MemoryOut, 10=IR[7:0], 11=ARF_AOut
- MuxCSel  out  1  0 = RF AOut, 1 = ARF AOut
- Flags  out  4  latched flag register
- State  out  3  current state code (debug)
- Halted  out  1  high while in HALT

Behaviour:
- Instruction format:
  - IR[15:12] = opcode
  - IR[11:10] = Rd (00=R1 .. 11=R4)
  - IR[9:8] = Rs
  - IR[7:0] = imm/addr
- Idle defaults in every state unless overridden:
  - all RSel/TSel = 0000, IR_Enable = 0, Mem_CS = 1, Mem_WR = 0;
  - all other selects and funsels = 0.
- Reset = 1:
  - outputs drive clear commands: ARF_RSel = 1111, RF_RSel = 1111, RF_TSel = 1111, ARF_FunSel = RF_FunSel = 00, IR_Enable = 1, IR_Funsel = 00;
  - next state = FETCH_L, Flags = 0000, Halted = 0;
  - reset mid-instruction aborts it; no memory write may be issued while Reset is high.
- States: FETCH_L = 0, FETCH_H = 1, EXEC0 = 2, EXEC1 = 3, HALT = 4.
- FETCH_L:
  - ARF_OutBSel = 11, Mem_CS = 0;
  - IR_Enable = 1, IR_Funsel = 01, IR_LH = 0;
  - ARF_RSel = 0001, ARF_FunSel = 11 (PC increment);
  - next state = FETCH_H.
- FETCH_H: same as FETCH_L but IR_LH = 1; next state = EXEC0. Instruction bytes are little-endian: M[PC] = low byte, M[PC+1] = high byte.
- EXEC0 by opcode (next state = FETCH_L unless stated):
  - 0 LDI: MuxASel = 10, RF_FunSel = 01, RF_RSel = onehot(Rd).
  - 1 LD / 2 ST: MuxBSel = 10, ARF_FunSel = 01, ARF_RSel = 1000 (AR <- imm); next state = EXEC1.
  - 3 ADD / 4 SUB / 5 AND / 6 OR / 7 XOR / 8 MOV:
    - RF_OutASel = Rd, RF_OutBSel = Rs, MuxCSel = 0;
    - ALU_FunSel = 0100 / 0101 / 0111 / 1000 / 1010 / 0001 respectively;
    - MuxASel = 00, RF_FunSel = 01, RF_RSel = onehot(Rd);
    - Flags <= ALUOutFlag at the same edge.
  - 9 JMP: MuxBSel = 10, ARF_FunSel = 01, ARF_RSel = 0001.
  - A BZ: performs the JMP action only if Flags[3] = 1.
  - D BNZ: performs the JMP action only if Flags[3] = 0.
  - B INC / C DEC: RF_FunSel = 11 / 10, RF_RSel = onehot(Rd). Flags are unchanged.
  - E: NOP.
  - F: HLT if HALT_EN = 1, otherwise NOP.
- EXEC1 (next state = FETCH_L):
  - LD: ARF_OutBSel = 00, Mem_CS = 0, Mem_WR = 0, MuxASel = 01, RF_FunSel = 01, RF_RSel = onehot(Rd).
  - ST: ARF_OutBSel = 00, RF_OutASel = Rd, MuxCSel = 0, ALU_FunSel = 0000, Mem_CS = 0, Mem_WR = 1.
- HALT: idle outputs, Halted = 1; remains in HALT until Reset.
- Instruction latency:
  - LDI/ALU/JMP/branch/INC/DEC/NOP: 3 cycles.
  - LD/ST: 4 cycles.
- Flags change only in ALU-op EXEC0 cycles. A branch sees the flags of the most recent ALU op.
- PC wraps 0xFF -> 0x00 naturally. The FETCH_H increment happens before a jump load, so the jump target overrides it.

Decomposition:
- Shared package alu_system_pkg holds:
  - opcode constants;
  - state codes;
  - ALU function codes;
  - mux, funsel and select encodings.
- Sub-module ctrl_decode: purely combinational; maps (state, IROut, Flags) to the control output bundle.
- The top level holds only the state register, the flag register and reset override.

Test Plan:
- Reset held 2 cycles:
  - ARF_RSel = 1111, RF_RSel = 1111, ARF_FunSel = 00, IR_Funsel = 00, Mem_WR = 0;
  - after release, State = 0 then 1 then 2.
- M[0..3] = 05,00,00,30 (LDI R1,5; ADD R1,R1):
  - cycle 2: RF_RSel = 1000, MuxASel = 10;
  - cycle 5: ALU_FunSel = 0100, RF_OutASel = RF_OutBSel = 100;
  - with ALUOutFlag = 0000 driven, Flags = 0000 afterward.
- SUB with ALUOutFlag = 1000, followed by BZ 0x40 (IR = 0xA040): EXEC0 drives ARF_RSel = 0001, MuxBSel = 10. Repeat with Flags[3] = 0: ARF_RSel = 0000.
- ST R2,0x80 (IR = 0x2480):
  - EXEC0: ARF_RSel = 1000;
  - EXEC1: Mem_WR = 1, Mem_CS = 0, ARF_OutBSel = 00, RF_OutASel = 101;
  - then FETCH_L.
- HLT (IR = 0xF000): Halted = 1 and State = 4 for 10+ cycles with no enables asserted. Reset returns to FETCH_L.
- Reset asserted during LD EXEC1: no RF load that cycle, clear commands issued, Flags = 0000.

Source files
------------

// File: rtl/alu_system_pkg.sv
// Shared encodings for the ALUSystem control sequencer: opcodes, state codes, ALU/mux/funsel codes.
// Also holds the control bundle struct and small helpers.
package alu_system_pkg;

    typedef enum logic [2:0] {
        ST_FETCH_L = 3'd0,
        ST_FETCH_H = 3'd1,
        ST_EXEC0   = 3'd2,
        ST_EXEC1   = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDI = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h1;
    localparam logic [3:0] OP_ST  = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_MOV = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_BZ  = 4'hA;
    localparam logic [3:0] OP_INC = 4'hB;
    localparam logic [3:0] OP_DEC = 4'hC;
    localparam logic [3:0] OP_BNZ = 4'hD;
    localparam logic [3:0] OP_NOP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] ALU_PASS_A = 4'b0000;
    localparam logic [3:0] ALU_MOV    = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0100;
    localparam logic [3:0] ALU_SUB    = 4'b0101;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_OR     = 4'b1000;
    localparam logic [3:0] ALU_XOR    = 4'b1010;

    localparam logic [1:0] FUN_CLR  = 2'b00;
    localparam logic [1:0] FUN_LOAD = 2'b01;
    localparam logic [1:0] FUN_DEC  = 2'b10;
    localparam logic [1:0] FUN_INC  = 2'b11;

    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_MEM = 2'b01;
    localparam logic [1:0] MUX_IMM = 2'b10;

    localparam logic [1:0] ARF_SEL_AR = 2'b00;
    localparam logic [1:0] ARF_SEL_PC = 2'b11;

    localparam logic [3:0] EN_NONE   = 4'b0000;
    localparam logic [3:0] EN_ALL    = 4'b1111;
    localparam logic [3:0] ARF_EN_AR = 4'b1000;
    localparam logic [3:0] ARF_EN_PC = 4'b0001;

    typedef struct packed {
        logic [1:0] arf_outa_sel;
        logic [1:0] arf_outb_sel;
        logic [1:0] arf_fun_sel;
        logic [3:0] arf_rsel;
        logic [1:0] rf_fun_sel;
        logic [3:0] rf_rsel;
        logic [3:0] rf_tsel;
        logic [2:0] rf_outa_sel;
        logic [2:0] rf_outb_sel;
        logic [3:0] alu_fun_sel;
        logic       mem_wr;
        logic       mem_cs;
        logic       ir_enable;
        logic       ir_lh;
        logic [1:0] ir_fun_sel;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic       mux_c_sel;
    } ctrl_t;

    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c        = '0;
        c.mem_cs = 1'b1;
        return c;
    endfunction

    function automatic logic [3:0] rf_onehot(input logic [1:0] r);
        return 4'b1000 >> r;
    endfunction

    function automatic logic [2:0] rf_read_sel(input logic [1:0] r);
        return {1'b1, r};
    endfunction

    function automatic logic [3:0] alu_code(input logic [3:0] op);
        logic [3:0] f;
        case (op)
            OP_ADD:  f = ALU_ADD;
            OP_SUB:  f = ALU_SUB;
            OP_AND:  f = ALU_AND;
            OP_OR:   f = ALU_OR;
            OP_XOR:  f = ALU_XOR;
            default: f = ALU_MOV;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/alu_system_ctrl_if.sv
// Control/status bundle between the sequencer (master) and ALUSystem (slave).
interface alu_system_ctrl_if;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [1:0]  ARF_OutASel;
    logic [1:0]  ARF_OutBSel;
    logic [1:0]  ARF_FunSel;
    logic [1:0]  RF_FunSel;
    logic [1:0]  IR_Funsel;
    logic [3:0]  ARF_RSel;
    logic [3:0]  RF_RSel;
    logic [3:0]  RF_TSel;
    logic [2:0]  RF_OutASel;
    logic [2:0]  RF_OutBSel;
    logic [3:0]  ALU_FunSel;
    logic        Mem_WR;
    logic        Mem_CS;
    logic        IR_Enable;
    logic        IR_LH;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic        MuxCSel;
    logic [3:0]  Flags;
    logic [2:0]  State;
    logic        Halted;

    modport master (
        input  IROut, ALUOutFlag,
        output ARF_OutASel, ARF_OutBSel, ARF_FunSel, RF_FunSel, IR_Funsel,
               ARF_RSel, RF_RSel, RF_TSel, RF_OutASel, RF_OutBSel, ALU_FunSel,
               Mem_WR, Mem_CS, IR_Enable, IR_LH, MuxASel, MuxBSel, MuxCSel,
               Flags, State, Halted
    );

    modport slave (
        output IROut, ALUOutFlag,
        input  ARF_OutASel, ARF_OutBSel, ARF_FunSel, RF_FunSel, IR_Funsel,
               ARF_RSel, RF_RSel, RF_TSel, RF_OutASel, RF_OutBSel, ALU_FunSel,
               Mem_WR, Mem_CS, IR_Enable, IR_LH, MuxASel, MuxBSel, MuxCSel,
               Flags, State, Halted
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational decode of (state, opcode/regs, Z flag) into the control bundle and next state.
// Zero latency; no backpressure, every state advances unconditionally except HALT.
module ctrl_decode
    import alu_system_pkg::*;
#(
    parameter bit HALT_EN = 1'b1
) (
    input  state_t     i_state,
    input  logic [7:0] i_ir_hi,
    input  logic       i_flag_z,
    output ctrl_t      o_ctrl,
    output state_t     o_next_state,
    output logic       o_flag_we
);

    logic [3:0] w_op;
    logic [1:0] w_rd;
    logic [1:0] w_rs;
    logic       w_jump;

    assign w_op = i_ir_hi[7:4];
    assign w_rd = i_ir_hi[3:2];
    assign w_rs = i_ir_hi[1:0];

    always_comb begin
        o_ctrl       = ctrl_idle();
        o_next_state = ST_FETCH_L;
        o_flag_we    = 1'b0;
        w_jump       = 1'b0;
        case (i_state)
            ST_FETCH_L, ST_FETCH_H: begin
                o_ctrl.arf_outb_sel = ARF_SEL_PC;
                o_ctrl.mem_cs       = 1'b0;
                o_ctrl.ir_enable    = 1'b1;
                o_ctrl.ir_fun_sel   = FUN_LOAD;
                o_ctrl.ir_lh        = (i_state == ST_FETCH_H);
                o_ctrl.arf_rsel     = ARF_EN_PC;
                o_ctrl.arf_fun_sel  = FUN_INC;
                o_next_state        = (i_state == ST_FETCH_H) ? ST_EXEC0 : ST_FETCH_H;
            end
            ST_EXEC0: begin
                case (w_op)
                    OP_LDI: begin
                        o_ctrl.mux_a_sel  = MUX_IMM;
                        o_ctrl.rf_fun_sel = FUN_LOAD;
                        o_ctrl.rf_rsel    = rf_onehot(w_rd);
                    end
                    OP_LD, OP_ST: begin
                        o_ctrl.mux_b_sel   = MUX_IMM;
                        o_ctrl.arf_fun_sel = FUN_LOAD;
                        o_ctrl.arf_rsel    = ARF_EN_AR;
                        o_next_state       = ST_EXEC1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: begin
                        o_ctrl.rf_outa_sel = rf_read_sel(w_rd);
                        o_ctrl.rf_outb_sel = rf_read_sel(w_rs);
                        o_ctrl.mux_c_sel   = 1'b0;
                        o_ctrl.alu_fun_sel = alu_code(w_op);
                        o_ctrl.mux_a_sel   = MUX_ALU;
                        o_ctrl.rf_fun_sel  = FUN_LOAD;
                        o_ctrl.rf_rsel     = rf_onehot(w_rd);
                        o_flag_we          = 1'b1;
                    end
                    OP_JMP: w_jump = 1'b1;
                    OP_BZ:  w_jump = i_flag_z;
                    OP_BNZ: w_jump = ~i_flag_z;
                    OP_INC, OP_DEC: begin
                        o_ctrl.rf_fun_sel = (w_op == OP_INC) ? FUN_INC : FUN_DEC;
                        o_ctrl.rf_rsel    = rf_onehot(w_rd);
                    end
                    OP_HLT: begin
                        if (HALT_EN) o_next_state = ST_HALT;
                    end
                    default: ;
                endcase
                // Jump target loads PC after the FETCH_H increment, so it wins.
                if (w_jump) begin
                    o_ctrl.mux_b_sel   = MUX_IMM;
                    o_ctrl.arf_fun_sel = FUN_LOAD;
                    o_ctrl.arf_rsel    = ARF_EN_PC;
                end
            end
            ST_EXEC1: begin
                o_ctrl.arf_outb_sel = ARF_SEL_AR;
                o_ctrl.mem_cs       = 1'b0;
                if (w_op == OP_LD) begin
                    o_ctrl.mux_a_sel  = MUX_MEM;
                    o_ctrl.rf_fun_sel = FUN_LOAD;
                    o_ctrl.rf_rsel    = rf_onehot(w_rd);
                end else begin
                    o_ctrl.rf_outa_sel = rf_read_sel(w_rd);
                    o_ctrl.mux_c_sel   = 1'b0;
                    o_ctrl.alu_fun_sel = ALU_PASS_A;
                    o_ctrl.mem_wr      = 1'b1;
                end
            end
            ST_HALT: o_next_state = ST_HALT;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_system_ctrl.sv
// Fetch/decode/execute sequencer for ALUSystem: 3-cycle ops, 4-cycle LD/ST, latched ALU flags.
// No backpressure; synchronous Reset overrides all outputs with clear commands.
module alu_system_ctrl
    import alu_system_pkg::*;
#(
    parameter bit HALT_EN = 1'b1
) (
    input  logic               Clock,
    input  logic               Reset,
    alu_system_ctrl_if.master  bus
);

    state_t     r_state;
    logic [3:0] r_flags;
    ctrl_t      w_dec;
    ctrl_t      w_ctrl;
    state_t     w_next_state;
    logic       w_flag_we;

    ctrl_decode #(.HALT_EN(HALT_EN)) u_decode (
        .i_state      (r_state),
        .i_ir_hi      (bus.IROut[15:8]),
        .i_flag_z     (r_flags[3]),
        .o_ctrl       (w_dec),
        .o_next_state (w_next_state),
        .o_flag_we    (w_flag_we)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_FETCH_L;
            r_flags <= 4'b0000;
        end else begin
            r_state <= w_next_state;
            if (w_flag_we) r_flags <= bus.ALUOutFlag;
        end
    end

    // Reset drives clear commands and suppresses any in-flight load or memory write.
    always_comb begin
        w_ctrl = w_dec;
        if (Reset) begin
            w_ctrl           = ctrl_idle();
            w_ctrl.arf_rsel  = EN_ALL;
            w_ctrl.rf_rsel   = EN_ALL;
            w_ctrl.rf_tsel   = EN_ALL;
            w_ctrl.ir_enable = 1'b1;
        end
    end

    assign bus.ARF_OutASel = w_ctrl.arf_outa_sel;
    assign bus.ARF_OutBSel = w_ctrl.arf_outb_sel;
    assign bus.ARF_FunSel  = w_ctrl.arf_fun_sel;
    assign bus.ARF_RSel    = w_ctrl.arf_rsel;
    assign bus.RF_FunSel   = w_ctrl.rf_fun_sel;
    assign bus.RF_RSel     = w_ctrl.rf_rsel;
    assign bus.RF_TSel     = w_ctrl.rf_tsel;
    assign bus.RF_OutASel  = w_ctrl.rf_outa_sel;
    assign bus.RF_OutBSel  = w_ctrl.rf_outb_sel;
    assign bus.ALU_FunSel  = w_ctrl.alu_fun_sel;
    assign bus.Mem_WR      = w_ctrl.mem_wr;
    assign bus.Mem_CS      = w_ctrl.mem_cs;
    assign bus.IR_Enable   = w_ctrl.ir_enable;
    assign bus.IR_LH       = w_ctrl.ir_lh;
    assign bus.IR_Funsel   = w_ctrl.ir_fun_sel;
    assign bus.MuxASel     = w_ctrl.mux_a_sel;
    assign bus.MuxBSel     = w_ctrl.mux_b_sel;
    assign bus.MuxCSel     = w_ctrl.mux_c_sel;
    assign bus.Flags       = r_flags;
    assign bus.State       = r_state;
    assign bus.Halted      = (r_state == ST_HALT) && !Reset;

endmodule

// File: tb/tb_alu_system_ctrl.sv
// Directed-vector bench for alu_system_ctrl; expected output bundles are queued per cycle
// and a negedge monitor pops and compares them against the DUT.
module tb_alu_system_ctrl;

    typedef struct packed {
        logic [2:0] state;
        logic       halted;
        logic [3:0] flags;
        logic [1:0] arf_outa;
        logic [1:0] arf_outb;
        logic [1:0] arf_fun;
        logic [1:0] rf_fun;
        logic [1:0] ir_fun;
        logic [3:0] arf_rsel;
        logic [3:0] rf_rsel;
        logic [3:0] rf_tsel;
        logic [2:0] rf_outa;
        logic [2:0] rf_outb;
        logic [3:0] alu_fun;
        logic       mem_wr;
        logic       mem_cs;
        logic       ir_en;
        logic       ir_lh;
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic       mux_c;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_system_ctrl_if bus();

    alu_system_ctrl #(.HALT_EN(1'b1)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    obs_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic [3:0] fl = 4'b0000;

    function automatic obs_t e_base(input logic [2:0] st, input logic [3:0] f);
        obs_t o = '0;
        o.state  = st;
        o.flags  = f;
        o.halted = (st == 3'd4);
        o.mem_cs = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_fetch(input logic lh, input logic [3:0] f);
        obs_t o = e_base(lh ? 3'd1 : 3'd0, f);
        o.arf_outb = 2'b11;
        o.mem_cs   = 1'b0;
        o.ir_en    = 1'b1;
        o.ir_fun   = 2'b01;
        o.ir_lh    = lh;
        o.arf_rsel = 4'b0001;
        o.arf_fun  = 2'b11;
        return o;
    endfunction

    function automatic obs_t e_rst(input logic [2:0] st, input logic [3:0] f);
        obs_t o = e_base(st, f);
        o.halted   = 1'b0;
        o.arf_rsel = 4'b1111;
        o.rf_rsel  = 4'b1111;
        o.rf_tsel  = 4'b1111;
        o.ir_en    = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_ldi(input logic [3:0] rsel, input logic [3:0] f);
        obs_t o = e_base(3'd2, f);
        o.mux_a   = 2'b10;
        o.rf_fun  = 2'b01;
        o.rf_rsel = rsel;
        return o;
    endfunction

    function automatic obs_t e_alu(input logic [3:0] alu, input logic [2:0] a, input logic [2:0] b,
                                   input logic [3:0] rsel, input logic [3:0] f);
        obs_t o = e_base(3'd2, f);
        o.alu_fun = alu;
        o.rf_outa = a;
        o.rf_outb = b;
        o.rf_fun  = 2'b01;
        o.rf_rsel = rsel;
        return o;
    endfunction

    function automatic obs_t e_jmp(input logic [3:0] f);
        obs_t o = e_base(3'd2, f);
        o.mux_b    = 2'b10;
        o.arf_fun  = 2'b01;
        o.arf_rsel = 4'b0001;
        return o;
    endfunction

    function automatic obs_t e_addr(input logic [3:0] f);
        obs_t o = e_base(3'd2, f);
        o.mux_b    = 2'b10;
        o.arf_fun  = 2'b01;
        o.arf_rsel = 4'b1000;
        return o;
    endfunction

    function automatic obs_t e_incdec(input logic [1:0] fun, input logic [3:0] rsel, input logic [3:0] f);
        obs_t o = e_base(3'd2, f);
        o.rf_fun  = fun;
        o.rf_rsel = rsel;
        return o;
    endfunction

    function automatic obs_t e_st1(input logic [2:0] a, input logic [3:0] f);
        obs_t o = e_base(3'd3, f);
        o.arf_outb = 2'b00;
        o.rf_outa  = a;
        o.mem_cs   = 1'b0;
        o.mem_wr   = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_ld1(input logic [3:0] rsel, input logic [3:0] f);
        obs_t o = e_base(3'd3, f);
        o.arf_outb = 2'b00;
        o.mem_cs   = 1'b0;
        o.mux_a    = 2'b01;
        o.rf_fun   = 2'b01;
        o.rf_rsel  = rsel;
        return o;
    endfunction

    task automatic cyc(input logic r, input logic [15:0] ir, input logic [3:0] af,
                       input obs_t e, input bit chk, input string nm);
        @(posedge clk);
        #1;
        rst            = r;
        bus.IROut      = ir;
        bus.ALUOutFlag = af;
        if (chk) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
    endtask

    task automatic instr(input logic [15:0] ir, input logic [3:0] af, input obs_t e0,
                         input bit two, input obs_t e1, input logic [3:0] new_fl, input string nm);
        cyc(1'b0, ir, 4'h0, e_fetch(1'b0, fl), 1'b1, {nm, "/fetch_l"});
        cyc(1'b0, ir, 4'h0, e_fetch(1'b1, fl), 1'b1, {nm, "/fetch_h"});
        cyc(1'b0, ir, af, e0, 1'b1, {nm, "/exec0"});
        fl = new_fl;
        if (two) cyc(1'b0, ir, 4'h0, e1, 1'b1, {nm, "/exec1"});
    endtask

    initial begin : monitor
        obs_t o;
        obs_t e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                o.state    = bus.State;
                o.halted   = bus.Halted;
                o.flags    = bus.Flags;
                o.arf_outa = bus.ARF_OutASel;
                o.arf_outb = bus.ARF_OutBSel;
                o.arf_fun  = bus.ARF_FunSel;
                o.rf_fun   = bus.RF_FunSel;
                o.ir_fun   = bus.IR_Funsel;
                o.arf_rsel = bus.ARF_RSel;
                o.rf_rsel  = bus.RF_RSel;
                o.rf_tsel  = bus.RF_TSel;
                o.rf_outa  = bus.RF_OutASel;
                o.rf_outb  = bus.RF_OutBSel;
                o.alu_fun  = bus.ALU_FunSel;
                o.mem_wr   = bus.Mem_WR;
                o.mem_cs   = bus.Mem_CS;
                o.ir_en    = bus.IR_Enable;
                o.ir_lh    = bus.IR_LH;
                o.mux_a    = bus.MuxASel;
                o.mux_b    = bus.MuxBSel;
                o.mux_c    = bus.MuxCSel;
                n_cmp++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL %s: got %h want %h (state %0d/%0d flags %h/%h)",
                             nm, o, e, o.state, e.state, o.flags, e.flags);
                end
            end
        end
    end

    initial begin : stim
        bus.IROut      = 16'h0000;
        bus.ALUOutFlag = 4'h0;
        cyc(1'b1, 16'h0000, 4'h0, e_rst(3'd0, 4'h0), 1'b0, "reset0");
        cyc(1'b1, 16'h0000, 4'h0, e_rst(3'd0, 4'h0), 1'b1, "reset1");

        instr(16'h0005, 4'h0, e_ldi(4'b1000, fl), 1'b0, '0, fl, "ldi_r1_5");
        instr(16'h3000, 4'h0, e_alu(4'b0100, 3'b100, 3'b100, 4'b1000, fl), 1'b0, '0, 4'h0, "add_r1_r1");
        instr(16'h4600, 4'h8, e_alu(4'b0101, 3'b101, 3'b110, 4'b0100, fl), 1'b0, '0, 4'h8, "sub_r2_r3");
        instr(16'hA040, 4'h0, e_jmp(fl), 1'b0, '0, 4'h8, "bz_taken");
        instr(16'h5C00, 4'h6, e_alu(4'b0111, 3'b111, 3'b100, 4'b0001, fl), 1'b0, '0, 4'h6, "and_r4_r1");
        instr(16'hA040, 4'h0, e_base(3'd2, fl), 1'b0, '0, 4'h6, "bz_not_taken");
        instr(16'hD010, 4'h0, e_jmp(fl), 1'b0, '0, 4'h6, "bnz_taken");
        instr(16'hB800, 4'hF, e_incdec(2'b11, 4'b0010, fl), 1'b0, '0, 4'h6, "inc_r3");
        instr(16'hC400, 4'hF, e_incdec(2'b10, 4'b0100, fl), 1'b0, '0, 4'h6, "dec_r2");
        instr(16'h6100, 4'h1, e_alu(4'b1000, 3'b100, 3'b101, 4'b1000, fl), 1'b0, '0, 4'h1, "or_r1_r2");
        instr(16'h7700, 4'hA, e_alu(4'b1010, 3'b101, 3'b111, 4'b0100, fl), 1'b0, '0, 4'hA, "xor_r2_r4");
        instr(16'h8800, 4'h4, e_alu(4'b0001, 3'b110, 3'b100, 4'b0010, fl), 1'b0, '0, 4'h4, "mov_r3_r1");
        instr(16'hD010, 4'h0, e_jmp(fl), 1'b0, '0, 4'h4, "bnz_z0_taken");
        instr(16'h9020, 4'h0, e_jmp(fl), 1'b0, '0, 4'h4, "jmp_20");
        instr(16'hE000, 4'hF, e_base(3'd2, fl), 1'b0, '0, 4'h4, "nop");
        instr(16'h2480, 4'h0, e_addr(fl), 1'b1, e_st1(3'b101, 4'h4), 4'h4, "st_r2_80");
        instr(16'h1C33, 4'h0, e_addr(fl), 1'b1, e_ld1(4'b0001, 4'h4), 4'h4, "ld_r4_33");

        // LD interrupted by reset in its EXEC1 cycle
        cyc(1'b0, 16'h1033, 4'h0, e_fetch(1'b0, fl), 1'b1, "ld_abort/fetch_l");
        cyc(1'b0, 16'h1033, 4'h0, e_fetch(1'b1, fl), 1'b1, "ld_abort/fetch_h");
        cyc(1'b0, 16'h1033, 4'h0, e_addr(fl), 1'b1, "ld_abort/exec0");
        cyc(1'b1, 16'h1033, 4'hF, e_rst(3'd3, fl), 1'b1, "ld_abort/reset");
        fl = 4'h0;

        instr(16'hF000, 4'h0, e_base(3'd2, fl), 1'b0, '0, fl, "hlt");
        for (int i = 0; i < 12; i++)
            cyc(1'b0, 16'h3000, 4'hF, e_base(3'd4, fl), 1'b1, "halt_hold");
        cyc(1'b1, 16'h0000, 4'h0, e_rst(3'd4, fl), 1'b1, "halt_reset");
        cyc(1'b0, 16'h0000, 4'h0, e_fetch(1'b0, fl), 1'b1, "after_halt/fetch_l");
        cyc(1'b0, 16'h0000, 4'h0, e_fetch(1'b1, fl), 1'b1, "after_halt/fetch_h");

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
